// File: rtl/scan_sequencer_if.sv
// Requester A/B handshake and scan-controller drive signals for scan_sequencer.
// The sequencer uses the slave view; requesters and the scan controller model use master.
interface scan_sequencer_if;
  logic       a_valid;
  logic       b_valid;
  logic [8:0] a_select;
  logic [8:0] b_select;
  logic [7:0] a_inputs;
  logic [7:0] b_inputs;
  logic       a_done;
  logic       b_done;
  logic [7:0] result;
  logic       err;
  logic [8:0] sc_active_select;
  logic [7:0] sc_inputs;
  logic       sc_ready;
  logic [7:0] sc_outputs;

  modport slave (
    input  a_valid, b_valid, a_select, b_select, a_inputs, b_inputs,
    input  sc_ready, sc_outputs,
    output a_done, b_done, result, err, sc_active_select, sc_inputs
  );

  modport master (
    output a_valid, b_valid, a_select, b_select, a_inputs, b_inputs,
    output sc_ready, sc_outputs,
    input  a_done, b_done, result, err, sc_active_select, sc_inputs
  );
endinterface

// File: rtl/scan_sequencer.sv
// Round-robin arbiter that runs one scan-controller load/result pass pair per request
// and returns the captured design output byte to the granted requester.
module scan_sequencer #(
  parameter int NUM_DESIGNS    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  scan_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    WAIT_LOAD,
    WAIT_RESULT,
    CAPTURE,
    FINISH
  } state_t;

  localparam logic [15:0] TO_TERM = 16'(TIMEOUT_CYCLES - 1);
  localparam logic        GRANT_A = 1'b0;
  localparam logic        GRANT_B = 1'b1;

  function automatic logic sel_in_range(input logic [8:0] sel);
    return int'(sel) < NUM_DESIGNS;
  endfunction

  state_t      state_q, state_d;
  logic [8:0]  sc_sel_q, sc_sel_d;
  logic [7:0]  sc_in_q, sc_in_d;
  logic [7:0]  result_q, result_d;
  logic        err_q, err_d;
  logic        a_done_q, a_done_d;
  logic        b_done_q, b_done_d;
  logic [15:0] cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;

  logic        any_valid;
  logic        win_b;
  logic [8:0]  win_sel;
  logic [7:0]  win_in;

  // On a tie the requester not granted last wins; otherwise whoever is asking.
  always_comb begin
    any_valid = bus.a_valid | bus.b_valid;
    win_b     = (bus.a_valid & bus.b_valid) ? (last_grant_q == GRANT_A) : bus.b_valid;
    win_sel   = win_b ? bus.b_select : bus.a_select;
    win_in    = win_b ? bus.b_inputs : bus.a_inputs;
  end

  always_comb begin
    state_d      = state_q;
    sc_sel_d     = sc_sel_q;
    sc_in_d      = sc_in_q;
    result_d     = 8'h00;
    err_d        = 1'b0;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;

    unique case (state_q)
      IDLE: begin
        if (any_valid) state_d = ARB;
      end
      ARB: begin
        if (!any_valid) begin
          state_d = IDLE;
        end else begin
          owner_d      = win_b;
          last_grant_d = win_b;
          if (!sel_in_range(win_sel)) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else begin
            sc_sel_d = win_sel;
            sc_in_d  = win_in;
            cnt_d    = 16'd0;
            state_d  = WAIT_LOAD;
          end
        end
      end
      WAIT_LOAD: begin
        // A ready on the terminal-count cycle still wins over the timeout.
        if (bus.sc_ready) begin
          cnt_d   = 16'd0;
          state_d = WAIT_RESULT;
        end else if (cnt_q == TO_TERM) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_RESULT: begin
        if (bus.sc_ready) begin
          state_d = CAPTURE;
        end else if (cnt_q == TO_TERM) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      CAPTURE: begin
        result_d = bus.sc_outputs;
        state_d  = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    a_done_d = (state_d == FINISH) && (owner_d == GRANT_A);
    b_done_d = (state_d == FINISH) && (owner_d == GRANT_B);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sc_sel_q     <= 9'd0;
      sc_in_q      <= 8'h00;
      result_q     <= 8'h00;
      err_q        <= 1'b0;
      a_done_q     <= 1'b0;
      b_done_q     <= 1'b0;
      cnt_q        <= 16'd0;
      last_grant_q <= GRANT_B;
      owner_q      <= GRANT_A;
    end else begin
      state_q      <= state_d;
      sc_sel_q     <= sc_sel_d;
      sc_in_q      <= sc_in_d;
      result_q     <= result_d;
      err_q        <= err_d;
      a_done_q     <= a_done_d;
      b_done_q     <= b_done_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
    end
  end

  assign bus.a_done           = a_done_q;
  assign bus.b_done           = b_done_q;
  assign bus.result           = result_q;
  assign bus.err              = err_q;
  assign bus.sc_active_select = sc_sel_q;
  assign bus.sc_inputs        = sc_in_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: a default-parameter instance for arbitration and data
// flow, and a TIMEOUT_CYCLES=16 instance for timeout and terminal-count behaviour.
module tb_scan_sequencer;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  int n_cmp = 0;
  int n_mis = 0;

  bit auto_rdy   = 1'b0;
  int rdy_period = 4;
  int rdy_cnt    = 0;

  scan_sequencer_if bus1();
  scan_sequencer_if bus2();

  always #5 clk = ~clk;

  scan_sequencer u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  scan_sequencer #(.TIMEOUT_CYCLES(16)) u_dut_to (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: the scan controller model echoes ~inputs after each ready edge.
  task automatic cyc();
    @(negedge clk);
    if (bus1.sc_ready) bus1.sc_outputs = ~bus1.sc_inputs;
    if (bus2.sc_ready) bus2.sc_outputs = ~bus2.sc_inputs;
    if (auto_rdy) begin
      rdy_cnt       = (rdy_cnt >= rdy_period - 1) ? 0 : rdy_cnt + 1;
      bus1.sc_ready = (rdy_cnt == 0);
    end
  endtask

  task automatic wait_done(input string tag, input bit want_b, input logic [8:0] exp_sel,
                           input logic [7:0] exp_in, input logic [7:0] exp_res,
                           input bit exp_err, input int budget, input bit drop);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      if (bus1.a_done || bus1.b_done) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_owner"},  32'(bus1.b_done), 32'(want_b));
      chk({tag, "_excl"},   32'(bus1.a_done & bus1.b_done), 32'd0);
      chk({tag, "_result"}, 32'(bus1.result), 32'(exp_res));
      chk({tag, "_err"},    32'(bus1.err), 32'(exp_err));
      chk({tag, "_sc_sel"}, 32'(bus1.sc_active_select), 32'(exp_sel));
      chk({tag, "_sc_in"},  32'(bus1.sc_inputs), 32'(exp_in));
      if (drop) begin
        if (want_b) bus1.b_valid = 1'b0;
        else        bus1.a_valid = 1'b0;
      end
      cyc();
      chk({tag, "_one_cycle"}, 32'({bus1.a_done, bus1.b_done}), 32'd0);
      chk({tag, "_res_clr"},   32'(bus1.result), 32'd0);
    end
  endtask

  initial begin
    bit seen2;
    int n;

    bus1.a_valid = 0; bus1.b_valid = 0; bus1.a_select = 0; bus1.b_select = 0;
    bus1.a_inputs = 0; bus1.b_inputs = 0; bus1.sc_ready = 0; bus1.sc_outputs = 0;
    bus2.a_valid = 0; bus2.b_valid = 0; bus2.a_select = 0; bus2.b_select = 0;
    bus2.a_inputs = 0; bus2.b_inputs = 0; bus2.sc_ready = 0; bus2.sc_outputs = 0;

    // Reset state
    reset_n = 1'b0;
    cyc(); cyc();
    chk("rst_a_done", 32'(bus1.a_done), 32'd0);
    chk("rst_b_done", 32'(bus1.b_done), 32'd0);
    chk("rst_result", 32'(bus1.result), 32'd0);
    chk("rst_err",    32'(bus1.err), 32'd0);
    chk("rst_sc_sel", 32'(bus1.sc_active_select), 32'd0);
    chk("rst_sc_in",  32'(bus1.sc_inputs), 32'd0);
    reset_n = 1'b1;

    // A: select 3, inputs 0xA5, controller ready every 258 cycles, design echoes ~inputs
    rdy_period = 258; rdy_cnt = 0; auto_rdy = 1'b1;
    bus1.a_valid = 1; bus1.a_select = 9'd3; bus1.a_inputs = 8'hA5;
    cyc(); cyc();
    chk("grant_sc_sel", 32'(bus1.sc_active_select), 32'd3);
    chk("grant_sc_in",  32'(bus1.sc_inputs), 32'hA5);
    wait_done("echo", 1'b0, 9'd3, 8'hA5, 8'h5A, 1'b0, 1000, 1'b1);

    // Tie after reset: A first, then B, and an A re-request loses to pending B
    reset_n = 1'b0; cyc(); reset_n = 1'b1;
    rdy_period = 4;
    bus1.a_valid = 1; bus1.a_select = 9'd1; bus1.a_inputs = 8'h11;
    bus1.b_valid = 1; bus1.b_select = 9'd2; bus1.b_inputs = 8'h22;
    wait_done("tie_a", 1'b0, 9'd1, 8'h11, 8'hEE, 1'b0, 40, 1'b0);
    bus1.a_inputs = 8'h33;
    wait_done("rr_b", 1'b1, 9'd2, 8'h22, 8'hDD, 1'b0, 40, 1'b1);
    wait_done("rr_a", 1'b0, 9'd1, 8'h33, 8'hCC, 1'b0, 40, 1'b1);

    // Valid dropped mid-transaction is ignored
    bus1.a_valid = 1; bus1.a_select = 9'd5; bus1.a_inputs = 8'h0F;
    cyc(); cyc();
    bus1.a_valid = 0;
    wait_done("drop_mid", 1'b0, 9'd5, 8'h0F, 8'hF0, 1'b0, 40, 1'b0);

    // Out-of-range select: error within 3 cycles, sc_* untouched
    bus1.b_valid = 1; bus1.b_select = 9'd8; bus1.b_inputs = 8'h77;
    wait_done("range", 1'b1, 9'd5, 8'h0F, 8'h00, 1'b1, 3, 1'b1);

    // Reset during WAIT_RESULT aborts; the re-request then completes
    auto_rdy = 1'b0; bus1.sc_ready = 0;
    bus1.a_valid = 1; bus1.a_select = 9'd4; bus1.a_inputs = 8'h3C;
    cyc(); cyc();
    bus1.sc_ready = 1; cyc(); bus1.sc_ready = 0;
    cyc(); cyc();
    reset_n = 1'b0; cyc();
    chk("abort_a_done", 32'(bus1.a_done), 32'd0);
    chk("abort_b_done", 32'(bus1.b_done), 32'd0);
    chk("abort_result", 32'(bus1.result), 32'd0);
    chk("abort_err",    32'(bus1.err), 32'd0);
    chk("abort_sc_sel", 32'(bus1.sc_active_select), 32'd0);
    chk("abort_sc_in",  32'(bus1.sc_inputs), 32'd0);
    reset_n = 1'b1;
    bus1.a_inputs = 8'h5C;
    rdy_period = 4; rdy_cnt = 0; auto_rdy = 1'b1;
    wait_done("post_rst", 1'b0, 9'd4, 8'h5C, 8'hA3, 1'b0, 40, 1'b1);
    auto_rdy = 1'b0; bus1.sc_ready = 0;

    // Timeout with TIMEOUT_CYCLES=16: done 16 cycles after WAIT_LOAD entry
    bus2.sc_ready = 0;
    bus2.a_valid = 1; bus2.a_select = 9'd0; bus2.a_inputs = 8'h01;
    cyc(); cyc();
    seen2 = 1'b0; n = 0;
    for (int i = 0; i < 40 && !seen2; i++) begin
      cyc(); n++;
      if (bus2.a_done) seen2 = 1'b1;
    end
    chk("to_seen",    32'(seen2), 32'd1);
    chk("to_latency", 32'(n), 32'd16);
    chk("to_err",     32'(bus2.err), 32'd1);
    chk("to_result",  32'(bus2.result), 32'd0);
    bus2.a_valid = 0;
    cyc();

    // Ready on the terminal-count cycle counts as ready
    bus2.a_valid = 1; bus2.a_select = 9'd2; bus2.a_inputs = 8'h40;
    cyc(); cyc();
    repeat (15) cyc();
    bus2.sc_ready = 1; cyc(); bus2.sc_ready = 0;
    chk("tc_no_done", 32'(bus2.a_done), 32'd0);
    chk("tc_no_err",  32'(bus2.err), 32'd0);
    bus2.sc_ready = 1; cyc(); bus2.sc_ready = 0;
    cyc();
    chk("tc_done",   32'(bus2.a_done), 32'd1);
    chk("tc_result", 32'(bus2.result), 32'hBF);
    chk("tc_err",    32'(bus2.err), 32'd0);
    bus2.a_valid = 0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_DESIGNS, default 8, meaning the number of designs on the scan chain; valid selects are 0..NUM_DESIGNS-1.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum cycles spent waiting for any one sc_ready pulse.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 Port: clk  input  1  sole clock, rising edge.
REQ-005 Port: reset_n  input  1  synchronous active-low reset.
REQ-006 Ports: a_valid / b_valid  input  1 each  request from requester A / B, held high until the matching done pulse.
REQ-007 Ports: a_select / b_select  input  9 each  design index requested.
REQ-008 Ports: a_inputs / b_inputs  input  8 each  input byte to drive into the selected design.
REQ-009 Ports: a_done / b_done  output  1 each  one-cycle completion pulse to the owning requester.
REQ-010 Port: result  output  8  design output byte, valid while a_done or b_done is high; 0x00 otherwise.
REQ-011 Port: err  output  1  high together with a done pulse when the request failed.
REQ-012 Port: sc_active_select  output  9  registered drive to the scan controller's design select.
REQ-013 Port: sc_inputs  output  8  registered drive to the scan controller's input byte.
REQ-014 Port: sc_ready  input  1  scan controller START-state pulse; the controller samples inputs and updates its outputs on this cycle.
REQ-015 Port: sc_outputs  input  8  scan controller output byte.

Function
REQ-016 The FSM SHALL have states IDLE, ARB, WAIT_LOAD, WAIT_RESULT, CAPTURE and FINISH.
REQ-017 IDLE: when a_valid or b_valid is high, go to ARB on the next cycle; sc_* SHALL hold their last values while in IDLE.
REQ-018 ARB arbitration: use round-robin through a last_grant register; when both requesters are valid, the requester not granted last SHALL win; when only one is valid, that one SHALL win.
REQ-019 ARB capture: in the ARB cycle, latch the winner's select and inputs into sc_active_select and sc_inputs, update last_grant and record the owner.
REQ-020 Select range check in ARB: if select >= NUM_DESIGNS, do not change sc_*, go to FINISH with err=1 and result=0x00.
REQ-021 WAIT_LOAD: wait for sc_ready=1 (the pass that loads the new inputs), then go to WAIT_RESULT; any pass already in progress at grant is discarded.
REQ-022 WAIT_RESULT: wait for the next sc_ready=1 (end of the loading pass; the controller updates its outputs on this edge), then go to CAPTURE.
REQ-023 CAPTURE: register sc_outputs into the result register, then go to FINISH.
REQ-024 FINISH: assert the owner's done for exactly one cycle with result and err, then return to IDLE.
REQ-025 The owner's valid SHALL be sampled low or high again only from IDLE onward; a new request is never granted in the FINISH cycle.
REQ-026 sc_active_select and sc_inputs SHALL be stable from the cycle after ARB through FINISH inclusive.
REQ-027 Timeout counter: a 16-bit counter is cleared on entry to WAIT_LOAD and to WAIT_RESULT and increments each cycle in those states.
REQ-028 Timeout exit: when the counter reaches TIMEOUT_CYCLES-1 without sc_ready, go to FINISH with err=1 and result=0x00.
REQ-029 Simultaneous events: sc_ready in the same cycle as the timeout terminal count SHALL count as ready (no error).
REQ-030 Valid deasserted by a requester mid-transaction SHALL be ignored; the transaction completes and done still pulses.
REQ-031 Both done outputs SHALL never be high in the same cycle.

Reset
REQ-032 While reset_n=0 at a clock edge, the block SHALL set state=IDLE, sc_active_select=0, sc_inputs=0, result=0x00, err=0, a_done=b_done=0, timeout counter=0 and last_grant=B, so A wins the first tie.
REQ-033 Reset asserted mid-transaction SHALL abort it with no done pulse; the requester must re-request.

Verification
REQ-034 Scenario: A requests select=3, inputs=0xA5; the controller model has ready every 258 cycles and design 3 echoes ~inputs -> sc_active_select=3 and sc_inputs=0xA5 the cycle after ARB, a_done one cycle after CAPTURE with result=0x5A and err=0.
REQ-035 Scenario: A and B valid in the same cycle after reset -> A is served first; B is granted on the next ARB; an A re-request while B is pending loses to B.
REQ-036 Scenario: B requests select=8 with NUM_DESIGNS=8 -> b_done with err=1 and result=0x00 within 3 cycles; sc_active_select unchanged.
REQ-037 Scenario: sc_ready held low after grant, TIMEOUT_CYCLES=16 -> done with err=1 exactly 16 cycles after WAIT_LOAD entry.
REQ-038 Scenario: reset_n pulsed low during WAIT_RESULT -> no done pulse, all outputs 0 the next cycle, and a subsequent A request completes normally.
REQ-039 Scenario: sc_ready asserted on the terminal-count cycle -> no error; the transaction proceeds to WAIT_RESULT.
